// File: rtl/vga_capture.sv
// VGA pixel-stream receiver: recovers x/y from BLANK_N/VS, writes a FB_W x FB_H crop
// into the framebuffer (adr = x + y*FB_W) and measures active geometry and lock.
module vga_capture #(
  parameter int FB_W  = 200,
  parameter int FB_H  = 150,
  parameter int ADR_W = 17
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_BLANK_N,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  output logic [ADR_W-1:0] fb_adr,
  output logic [23:0]      fb_d,
  output logic             fb_we,
  output logic             frame_done,
  output logic [9:0]       h_active,
  output logic [9:0]       v_active,
  output logic             locked,
  output logic             line_err
);

  localparam logic [9:0]       CNT_MAX = 10'd1023;
  localparam logic [9:0]       FB_W_C  = 10'(FB_W);
  localparam logic [9:0]       FB_H_C  = 10'(FB_H);
  localparam logic [ADR_W-1:0] FB_W_A  = ADR_W'(FB_W);

  typedef enum logic [1:0] {SEEK, SYNC, ACTIVE} state_t;

  // Saturating increment: {hit_max, next_value}; the counter sticks at CNT_MAX.
  function automatic logic [10:0] sat_inc(input logic [9:0] v);
    if (v == CNT_MAX) return {1'b1, v};
    else              return {1'b0, v + 10'd1};
  endfunction

  logic        vld_p0;
  logic        vs_p0, blank_p0;
  logic        vs_prv_p0, blank_prv_p0;
  logic        unused_hs_p0;
  logic [23:0] rgb_p0;

  state_t      state;
  logic [9:0]  x, y, ref_len;
  logic        frame_err, have_prev;

  logic        vs_fall, blank_fall, pix_ok;
  logic [9:0]  x_nx, y_nx, ref_nx, x_inc, y_inc;
  logic        x_sat, y_sat, err_nx, wr_hit;
  logic [ADR_W-1:0] wr_adr;

  // ---- stage p0: input sample register (advances only on pix_en) ----
  // The *_prv_p0 copies hold the previous sample, so edges are per-sample, not per-cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      vs_p0        <= 1'b1;
      blank_p0     <= 1'b0;
      vs_prv_p0    <= 1'b1;
      blank_prv_p0 <= 1'b0;
      unused_hs_p0 <= 1'b1;
    end else begin
      vld_p0 <= pix_en;
      if (pix_en) begin
        vs_p0        <= VGA_VS;
        blank_p0     <= VGA_BLANK_N;
        vs_prv_p0    <= vs_p0;
        blank_prv_p0 <= blank_p0;
        unused_hs_p0 <= VGA_HS;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (pix_en) rgb_p0 <= {VGA_R, VGA_G, VGA_B};
  end

  assign vs_fall    = vld_p0 & vs_prv_p0 & ~vs_p0;
  assign blank_fall = vld_p0 & blank_prv_p0 & ~blank_p0;
  assign pix_ok     = vld_p0 & blank_p0 & ~vs_fall;
  assign wr_adr     = ADR_W'(x) + ADR_W'(y) * FB_W_A;

  always_comb begin
    x_nx   = x;
    y_nx   = y;
    ref_nx = ref_len;
    err_nx = frame_err;
    wr_hit = 1'b0;
    {x_sat, x_inc} = sat_inc(x);
    {y_sat, y_inc} = sat_inc(y);
    if (blank_fall) begin
      if (y == '0)             ref_nx = x;
      else if (x != ref_len)   err_nx = 1'b1;
      x_nx = '0;
      y_nx = y_inc;
      if (y_sat) err_nx = 1'b1;
    end else if (pix_ok) begin
      wr_hit = (x < FB_W_C) && (y < FB_H_C);
      x_nx   = x_inc;
      if (x_sat) err_nx = 1'b1;
    end
  end

  // ---- stage p1: capture FSM and registered framebuffer/status outputs ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= SEEK;
      x          <= '0;
      y          <= '0;
      ref_len    <= '0;
      frame_err  <= 1'b0;
      have_prev  <= 1'b0;
      fb_we      <= 1'b0;
      fb_adr     <= '0;
      fb_d       <= '0;
      frame_done <= 1'b0;
      h_active   <= '0;
      v_active   <= '0;
      locked     <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (wr_hit && state != SEEK) begin
        fb_we  <= 1'b1;
        fb_adr <= wr_adr;
        fb_d   <= rgb_p0;
      end
      case (state)
        SEEK: begin
          if (vs_fall) state <= SYNC;
        end
        SYNC: begin
          if (vs_fall) begin
            frame_done <= 1'b1;
            h_active   <= ref_len;
            v_active   <= y;
            line_err   <= frame_err;
            locked     <= 1'b0;
            have_prev  <= 1'b1;
          end else if (pix_ok) begin
            // First valid pixel of the frame is captured, not just used as a trigger.
            x         <= x_nx;
            frame_err <= err_nx;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_fall) begin
            // A line ending on this same sample is already folded into the *_nx values.
            frame_done <= 1'b1;
            h_active   <= ref_nx;
            v_active   <= y_nx;
            line_err   <= err_nx;
            locked     <= have_prev && !line_err && !err_nx &&
                          (ref_nx == h_active) && (y_nx == v_active);
            have_prev  <= 1'b1;
            x          <= '0;
            y          <= '0;
            ref_len    <= '0;
            frame_err  <= 1'b0;
            state      <= SYNC;
          end else begin
            x         <= x_nx;
            y         <= y_nx;
            ref_len   <= ref_nx;
            frame_err <= err_nx;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: directed frame sequence driving a write/frame scoreboard.
`timescale 1ns/1ps
module tb_vga_capture;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_N = 1'b0;
  logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic [16:0] fb_adr;
  logic [23:0] fb_d;
  logic        fb_we, frame_done, locked, line_err;
  logic [9:0]  h_active, v_active;

  vga_capture #(.FB_W(200), .FB_H(150), .ADR_W(17)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(pix_en),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .fb_adr(fb_adr), .fb_d(fb_d), .fb_we(fb_we), .frame_done(frame_done),
    .h_active(h_active), .v_active(v_active), .locked(locked), .line_err(line_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { logic [16:0] adr; logic [23:0] d; } wr_t;
  typedef struct { int h; int v; logic lock; logic err; int nw; } fr_t;

  wr_t wq[$];
  fr_t fq[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;
  int  opt_short = -1, opt_gap = -1, opt_reset = -1, opt_rate = 2;
  bit  opt_early = 1'b0;
  int  frame_id = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s actual=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string when);
    check({when, "_fb_we"}, 32'(fb_we), 0);
    check({when, "_fb_adr"}, 32'(fb_adr), 0);
    check({when, "_fb_d"}, 32'(fb_d), 0);
    check({when, "_frame_done"}, 32'(frame_done), 0);
    check({when, "_h_active"}, 32'(h_active), 0);
    check({when, "_v_active"}, 32'(v_active), 0);
    check({when, "_locked"}, 32'(locked), 0);
    check({when, "_line_err"}, 32'(line_err), 0);
  endtask

  // Scoreboard consumer: every write and frame_done must match the next queued expectation.
  always @(negedge CLOCK_50) begin
    wr_t e;
    fr_t f;
    if (reset) begin
      wr_cnt = 0;
    end else begin
      if (fb_we) begin
        check("wr_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("fb_adr", 32'(fb_adr), 32'(e.adr));
          check("fb_d", 32'(fb_d), 32'(e.d));
        end
        wr_cnt++;
      end
      if (frame_done) begin
        check("fd_expected", 32'(fq.size() > 0), 1);
        if (fq.size() > 0) begin
          f = fq.pop_front();
          check("h_active", 32'(h_active), 32'(f.h));
          check("v_active", 32'(v_active), 32'(f.v));
          check("locked", 32'(locked), 32'(f.lock));
          check("line_err", 32'(line_err), 32'(f.err));
          check("frame_writes", 32'(wr_cnt), 32'(f.nw));
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic sample(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_N = blank;
    {VGA_R, VGA_G, VGA_B} = rgb;
    pix_en = 1'b1;
    @(posedge CLOCK_50); #1;
    pix_en = 1'b0;
    repeat (opt_rate - 1) begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  // One frame: V active lines of H pixels, each line H+4 samples, 3 blank lines,
  // VS low for line V+1 (or, early mode, starting on the last line's first blank sample).
  task automatic run_frame(input int H, input int V, input bit cap, input bit fd,
                           input int eh, input int ev, input bit el, input bit ee);
    int LT, vs_start, nw, k, hl;
    bit c;
    logic blank, vs, hs;
    logic [23:0] rgb;
    LT = H + 4;
    vs_start = opt_early ? (V - 1) * LT + H : (V + 1) * LT;
    nw = 0;
    c = cap;
    for (int row = 0; row < V + 3; row++) begin
      for (int col = 0; col < LT; col++) begin
        k  = row * LT + col;
        hl = (row == opt_short) ? H - 1 : H;
        if (row == opt_reset && col == 0) begin
          reset = 1'b1;
          #1;
          check_reset_outputs("midreset");
          wq.delete();
          fq.delete();
          c = 1'b0;
          @(posedge CLOCK_50); #1;
          reset = 1'b0;
        end
        if (row == opt_gap && col == 10) begin
          repeat (50) @(posedge CLOCK_50);
          #1;
        end
        blank = (row < V) && (col < hl);
        vs    = !(k >= vs_start && k < vs_start + LT);
        hs    = !(col == hl + 1 || col == hl + 2);
        rgb   = (row == 2 && col == 3) ? 24'h123456 : {8'(col), 8'(row), 8'(frame_id)};
        if (k == vs_start && fd && c) fq.push_back('{eh, ev, el, ee, nw});
        if (c && blank && k != vs_start && col < 200 && row < 150) begin
          wq.push_back('{17'(col + row * 200), rgb});
          nw++;
        end
        sample(hs, vs, blank, rgb);
      end
    end
    frame_id++;
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge CLOCK_50); #1;

    opt_rate = 2;
    run_frame(24, 8, 0, 0, 0, 0, 0, 0);       // skipped while waiting for VS
    run_frame(24, 8, 1, 1, 24, 8, 0, 0);      // first captured, never locked
    run_frame(24, 8, 1, 1, 24, 8, 1, 0);      // stable -> locked
    opt_short = 3;
    run_frame(24, 8, 1, 1, 24, 8, 0, 1);      // short line -> error
    opt_short = -1;
    opt_gap = 2;
    run_frame(24, 8, 1, 1, 24, 8, 0, 0);      // clean, pix_en gap mid-line
    opt_gap = -1;
    run_frame(24, 8, 1, 1, 24, 8, 1, 0);      // lock restored
    opt_rate = 1;
    run_frame(202, 151, 1, 1, 202, 151, 0, 0); // crop edges, 30000 writes
    opt_rate = 2;
    opt_early = 1'b1;
    run_frame(24, 8, 1, 1, 24, 8, 0, 0);      // line end and VS fall on one sample
    opt_early = 1'b0;
    run_frame(24, 8, 1, 1, 24, 8, 1, 0);
    opt_rate = 1;
    run_frame(1030, 2, 1, 1, 1023, 2, 0, 1);  // x saturates at 1023
    opt_rate = 2;
    opt_reset = 4;
    run_frame(24, 8, 1, 0, 0, 0, 0, 0);       // aborted by reset at line 4
    opt_reset = -1;
    run_frame(24, 8, 1, 1, 24, 8, 0, 0);      // first frame after reset
    run_frame(24, 8, 1, 1, 24, 8, 1, 0);

    repeat (10) @(posedge CLOCK_50);
    #1;
    check("writes_left", 32'(wq.size()), 0);
    check("frames_left", 32'(fq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
